// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with press/release debounce, ghost rejection and key FIFO.
// Define KEYPAD_AUTOREPEAT_EN to re-push a held single key periodically.
module keypad_scan_fifo #(
  parameter  int ROWS            = 4,
  parameter  int COLS            = 4,
  parameter  int SCAN_CYCLES     = 8,
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int REPEAT_DELAY    = 64,
  parameter  int REPEAT_PERIOD   = 32,
  localparam int KEY_W           = $clog2(ROWS*COLS),
  localparam int NW              = $clog2(FIFO_DEPTH+1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [NW-1:0]    fifo_count,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             key_down,
  output logic [2:0]       scan_state
);

  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] T_LAST = TW'(SCAN_CYCLES-1);
  localparam logic [TW-1:0] T_MASK = TW'(2);
  localparam logic [CW-1:0] C_LAST = CW'(COLS-1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [NW-1:0] N_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_SCAN = 3'd0,
    S_DBP  = 3'd1,
    S_PUSH = 3'd2,
    S_HOLD = 3'd3,
    S_DBR  = 3'd4
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [TW-1:0]   tmr_q;
  logic [DW-1:0]   cnt_q;
  logic [ROWS-1:0] sync_q, rs_q, pat_q;
  logic            key_down_q;

  logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    fcnt_q, fcnt_d;
  logic             ovf_q;

  logic             idle_c, single_c, rel_done_c;
  logic             push_c, pop_c, full_c, wr_c, rep_fire_c;
  logic [KEY_W-1:0] row_c, key_c;

  assign idle_c     = &rs_q;
  assign single_c   = ($countones(~pat_q) == 1);
  assign rel_done_c = (state_q == S_DBR) && idle_c && (cnt_q == D_LAST);

  always_comb begin
    row_c = '0;
    for (int r = 0; r < ROWS; r++)
      if (!pat_q[r]) row_c = KEY_W'(r);
  end

  assign key_c = row_c * KEY_W'(COLS) + KEY_W'(col_q);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_q <= '1;
      rs_q   <= '1;
    end else begin
      sync_q <= row_in;
      rs_q   <= sync_q;
    end
  end

  // Timer < 2 after a column change: rs still reflects the previous column.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_SCAN;
      col_q      <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= '1;
      key_down_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_SCAN: begin
          if (!idle_c && tmr_q >= T_MASK) begin
            pat_q   <= rs_q;
            cnt_q   <= '0;
            state_q <= S_DBP;
          end else if (tmr_q == T_LAST) begin
            tmr_q <= '0;
            col_q <= (col_q == C_LAST) ? '0 : col_q + CW'(1);
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_DBP: begin
          if (idle_c) begin
            tmr_q   <= '0;
            state_q <= S_SCAN;
          end else if (rs_q != pat_q) begin
            pat_q <= rs_q;
            cnt_q <= '0;
          end else if (cnt_q == D_LAST) begin
            state_q <= single_c ? S_PUSH : S_HOLD;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        S_PUSH: begin
          key_down_q <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (idle_c) begin
            cnt_q   <= '0;
            state_q <= S_DBR;
          end
        end
        S_DBR: begin
          if (!idle_c) begin
            state_q <= S_HOLD;
          end else if (cnt_q == D_LAST) begin
            tmr_q      <= '0;
            key_down_q <= 1'b0;
            state_q    <= S_SCAN;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY-1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD-1);

  logic [RW-1:0] rep_q;
  logic          rep_arm_q;

  assign rep_fire_c = (state_q == S_HOLD) && key_down_q &&
                      (rep_q == (rep_arm_q ? R_NEXT : R_FIRST));

  // Timer pauses through release bounces; only a completed release clears it.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rep_q     <= '0;
      rep_arm_q <= 1'b0;
    end else if (rel_done_c) begin
      rep_q     <= '0;
      rep_arm_q <= 1'b0;
    end else if (state_q == S_HOLD && key_down_q) begin
      if (rep_fire_c) begin
        rep_q     <= '0;
        rep_arm_q <= 1'b1;
      end else begin
        rep_q <= rep_q + RW'(1);
      end
    end
  end
`else
  logic unused_rep;
  assign unused_rep = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rep_fire_c = 1'b0;
`endif

  assign push_c = (state_q == S_PUSH) || rep_fire_c;
  assign pop_c  = key_valid && key_ready;
  assign full_c = (fcnt_q == N_FULL);
  assign wr_c   = push_c && (!full_c || pop_c);

  always_comb begin
    fcnt_d = fcnt_q;
    if (wr_c && !pop_c) fcnt_d = fcnt_q + NW'(1);
    else if (!wr_c && pop_c) fcnt_d = fcnt_q - NW'(1);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= key_c;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      fcnt_q <= fcnt_d;
      if (push_c && full_c && !pop_c) ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign col_out    = ~(COLS'(1) << col_q);
  assign key_code   = mem_q[rd_ptr_q];
  assign key_valid  = (fcnt_q != '0);
  assign fifo_count = fcnt_q;
  assign overflow   = ovf_q;
  assign key_down   = key_down_q;
  assign scan_state = state_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: keypad switch model plus per-scenario tasks.
// Expected values are hand-derived for the default parameter set.
module tb_keypad_scan_fifo;

  logic        clk;
  logic        RST;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;
  logic        key_down;
  logic [2:0]  scan_state;
  logic [15:0] keys;

  int total;
  int bad;

  keypad_scan_fifo dut (
    .clk          (clk),
    .RST          (RST),
    .row_in       (row_in),
    .col_out      (col_out),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .key_down     (key_down),
    .scan_state   (scan_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed switch (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic press_key(input int idx, input int hold);
    int n;
    keys = 16'(1) << idx;
    n = 0;
    while (key_down !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (key_down !== 1'b1) begin
      bad++;
      $display("FAIL press_%0d_down got=%b want=1", idx, key_down);
    end
    repeat (hold) @(negedge clk);
    keys = '0;
    n = 0;
    while ((scan_state !== 3'd0 || key_down !== 1'b0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (scan_state !== 3'd0) begin
      bad++;
      $display("FAIL release_%0d_state got=%0d want=0", idx, scan_state);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    keys = '0;
    key_ready = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    total += 7;
    if (col_out !== 4'b1110) begin
      bad++; $display("FAIL rst_col got=%b want=1110", col_out);
    end
    if (key_code !== 4'd0) begin
      bad++; $display("FAIL rst_code got=%0d want=0", key_code);
    end
    if (key_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", key_valid);
    end
    if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL rst_count got=%0d want=0", fifo_count);
    end
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL rst_ovf got=%b want=0", overflow);
    end
    if (key_down !== 1'b0) begin
      bad++; $display("FAIL rst_down got=%b want=0", key_down);
    end
    if (scan_state !== 3'd0) begin
      bad++; $display("FAIL rst_state got=%0d want=0", scan_state);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_press();
    int n;
    n = 0;
    while (col_out !== 4'b1101 && n < 40) begin
      @(negedge clk);
      n++;
    end
    keys = 16'(1) << 6;
    n = 0;
    while (col_out !== 4'b1011 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (col_out !== 4'b1011) begin
      bad++; $display("FAIL single_col got=%b want=1011", col_out);
    end
    n = 0;
    while (key_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total += 3;
    if (n != 20) begin
      bad++; $display("FAIL single_latency got=%0d want=20", n);
    end
    if (key_code !== 4'd6) begin
      bad++; $display("FAIL single_code got=%0d want=6", key_code);
    end
    if (key_down !== 1'b1) begin
      bad++; $display("FAIL single_down_early got=%b want=1", key_down);
    end
    repeat (100) @(negedge clk);
    total += 3;
    if (key_down !== 1'b1) begin
      bad++; $display("FAIL single_down got=%b want=1", key_down);
    end
    if (scan_state !== 3'd3) begin
      bad++; $display("FAIL single_hold got=%0d want=3", scan_state);
    end
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_count got=%0d want=1", fifo_count);
    end
    keys = '0;
    repeat (40) @(negedge clk);
    total += 3;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_rel_count got=%0d want=1", fifo_count);
    end
    if (key_down !== 1'b0) begin
      bad++; $display("FAIL single_rel_down got=%b want=0", key_down);
    end
    if (scan_state !== 3'd0) begin
      bad++; $display("FAIL single_rel_state got=%0d want=0", scan_state);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0) begin
      bad++; $display("FAIL single_pop got=%b want=0", key_valid);
    end
  endtask

  task automatic test_bounce();
    keys = '0;
    for (int i = 0; i < 8; i++) begin
      keys[0] = ~keys[0];
      repeat (5) @(negedge clk);
    end
    total++;
    if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL bounce_press_count got=%0d want=0", fifo_count);
    end
    keys[0] = 1'b1;
    repeat (80) @(negedge clk);
    total += 3;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL bounce_held_count got=%0d want=1", fifo_count);
    end
    if (key_code !== 4'd0) begin
      bad++; $display("FAIL bounce_code got=%0d want=0", key_code);
    end
    if (key_down !== 1'b1) begin
      bad++; $display("FAIL bounce_down got=%b want=1", key_down);
    end
    for (int i = 0; i < 8; i++) begin
      keys[0] = ~keys[0];
      repeat (5) @(negedge clk);
    end
    keys = '0;
    repeat (40) @(negedge clk);
    total += 2;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL bounce_rel_count got=%0d want=1", fifo_count);
    end
    if (scan_state !== 3'd0) begin
      bad++; $display("FAIL bounce_rel_state got=%0d want=0", scan_state);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_overflow();
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) press_key(k, 5);
    total += 3;
    if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count);
    end
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_flag got=%b want=1", overflow);
    end
    if (key_code !== 4'd0) begin
      bad++; $display("FAIL ovf_head got=%0d want=0", key_code);
    end
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (key_code !== 4'(i) || key_valid !== 1'b1) begin
        bad++;
        $display("FAIL ovf_drain_%0d got=%0d/%b want=%0d/1", i, key_code, key_valid, i);
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
    total += 2;
    if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL ovf_drained got=%0d want=0", fifo_count);
    end
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b want=1", overflow);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    int exp_q [4] = '{1, 2, 3, 5};
    for (int k = 0; k < 4; k++) press_key(k, 5);
    keys = 16'(1) << 5;
    n = 0;
    while (scan_state !== 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (scan_state !== 3'd2) begin
      bad++; $display("FAIL fpp_push_state got=%0d want=2", scan_state);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total += 3;
    if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL fpp_count got=%0d want=4", fifo_count);
    end
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL fpp_ovf got=%b want=0", overflow);
    end
    if (key_code !== 4'd1) begin
      bad++; $display("FAIL fpp_head got=%0d want=1", key_code);
    end
    keys = '0;
    n = 0;
    while (scan_state !== 3'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (key_code !== 4'(exp_q[i])) begin
        bad++;
        $display("FAIL fpp_drain_%0d got=%0d want=%0d", i, key_code, exp_q[i]);
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
  endtask

  task automatic test_ghost();
    int n;
    keys = (16'(1) << 3) | (16'(1) << 11);
    n = 0;
    while (scan_state !== 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total += 2;
    if (scan_state !== 3'd3) begin
      bad++; $display("FAIL ghost_hold got=%0d want=3", scan_state);
    end
    if (key_down !== 1'b0) begin
      bad++; $display("FAIL ghost_down got=%b want=0", key_down);
    end
    repeat (30) @(negedge clk);
    total++;
    if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL ghost_count got=%0d want=0", fifo_count);
    end
    keys = '0;
    n = 0;
    while (scan_state !== 3'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    press_key(3, 5);
    total += 2;
    if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL ghost_after_count got=%0d want=1", fifo_count);
    end
    if (key_code !== 4'd3) begin
      bad++; $display("FAIL ghost_after_code got=%0d want=3", key_code);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_repeat();
    int exp_n;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    press_key(5, 170);
    total += 2;
    if (fifo_count !== 3'(exp_n)) begin
      bad++; $display("FAIL repeat_count got=%0d want=%0d", fifo_count, exp_n);
    end
    if (key_code !== 4'd5) begin
      bad++; $display("FAIL repeat_code got=%0d want=5", key_code);
    end
  endtask

  task automatic test_reset_mid();
    RST = 1'b1;
    #1;
    total += 2;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_fifo got=%0d/%b want=0/0", fifo_count, key_valid);
    end
    if (scan_state !== 3'd0) begin
      bad++; $display("FAIL midrst_state got=%0d want=0", scan_state);
    end
    @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_full_push_pop();
    test_ghost();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
